// File: rtl/rv32i_types.sv
// Shared types for the icache line adaptor: FSM state encoding and memory burst geometry.
package rv32i_types;

  localparam int BURST_W   = 64;
  localparam int BURST_LEN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } adaptor_state_t;

endpackage

// File: rtl/icache_line_adaptor_line_assembler.sv
// Beat counter plus line register: each accepted memory beat lands in the next
// BURST_W slice of the line, beat 0 in the lowest bits.
module line_assembler #(
  parameter int S_LINE  = 256,
  parameter int BURST_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               beat_en_i,
  input  logic [BURST_W-1:0] beat_data_i,
  output logic [S_LINE-1:0]  line_o,
  output logic               last_beat_o
);

  localparam int BEATS = S_LINE / BURST_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [S_LINE-1:0] line_q, line_d;

  // Clearing only rewinds the counter; the previous line stays visible until overwritten.
  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (beat_en_i) begin
      line_d[int'(cnt_q) * BURST_W +: BURST_W] = beat_data_i;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign line_o      = line_q;
  assign last_beat_o = beat_en_i && !clear_i && (cnt_q == CNT_W'(BEATS - 1));

endmodule

// File: rtl/icache_line_adaptor.sv
// Turns an icache line miss into a BURST_LEN-beat memory burst and returns the assembled line.
// Optional last-line buffer enabled with ICACHE_LINE_ADAPTOR_LBUF_EN.
module icache_line_adaptor
  import rv32i_types::*;
#(
  parameter int S_OFFSET = 5,
  parameter int S_LINE   = rv32i_types::BURST_LEN * rv32i_types::BURST_W,
  parameter int BURST_W  = rv32i_types::BURST_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               line_read,
  input  logic [31:0]        line_addr,
  output logic [S_LINE-1:0]  line_rdata,
  output logic               line_resp,
  output logic [31:0]        burst_addr,
  output logic               burst_read,
  input  logic [BURST_W-1:0] burst_rdata,
  input  logic               burst_resp,
  output adaptor_state_t     dbg_state
);

  // Handshake: line_read is held by the icache until the one-cycle line_resp strobe;
  // burst_resp qualifies burst_rdata on any edge while burst_read is high.

  adaptor_state_t state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic           clear, beat_en, last_beat, lbuf_hit;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^line_addr[S_OFFSET-1:0];

  line_assembler #(
    .S_LINE  (S_LINE),
    .BURST_W (BURST_W)
  ) u_asm (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .beat_en_i   (beat_en),
    .beat_data_i (burst_rdata),
    .line_o      (line_rdata),
    .last_beat_o (last_beat)
  );

  assign beat_en = (state_q == BURST) && burst_resp;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_read) begin
          addr_d = {line_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
          if (lbuf_hit) begin
            state_d = DONE;
          end else begin
            clear   = 1'b1;
            state_d = BURST;
          end
        end
      end
      BURST:   if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef ICACHE_LINE_ADAPTOR_LBUF_EN
  localparam int TAG_W = 32 - S_OFFSET;

  logic             lbuf_valid_q, lbuf_valid_d;
  logic [TAG_W-1:0] lbuf_tag_q, lbuf_tag_d;

  assign lbuf_hit = lbuf_valid_q && (lbuf_tag_q == line_addr[31:S_OFFSET]);

  // A starting burst overwrites the line, so the buffered tag is dropped until it completes.
  always_comb begin
    lbuf_valid_d = lbuf_valid_q;
    lbuf_tag_d   = lbuf_tag_q;
    if (clear) begin
      lbuf_valid_d = 1'b0;
    end else if (last_beat) begin
      lbuf_valid_d = 1'b1;
      lbuf_tag_d   = addr_q[31:S_OFFSET];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lbuf_valid_q <= 1'b0;
      lbuf_tag_q   <= '0;
    end else begin
      lbuf_valid_q <= lbuf_valid_d;
      lbuf_tag_q   <= lbuf_tag_d;
    end
  end
`else
  assign lbuf_hit = 1'b0;
`endif

  assign burst_read = (state_q == BURST);
  assign burst_addr = burst_read ? addr_q : 32'h0;
  assign line_resp  = (state_q == DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_icache_line_adaptor.sv
// Directed plus randomized checks of icache_line_adaptor against a line-level reference model.
module tb_icache_line_adaptor;
  import rv32i_types::*;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           line_read;
  logic [31:0]    line_addr;
  logic [255:0]   line_rdata;
  logic           line_resp;
  logic [31:0]    burst_addr;
  logic           burst_read;
  logic [63:0]    burst_rdata;
  logic           burst_resp;
  adaptor_state_t dbg_state;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [255:0] exp_q[$];
  logic [255:0] last_line;
  bit           lb_valid;
  logic [26:0]  lb_tag;
  logic [63:0]  beat_v[4];
  int           gap_v[4];

  icache_line_adaptor dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line_read   (line_read),
    .line_addr   (line_addr),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .burst_addr  (burst_addr),
    .burst_read  (burst_read),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    last_line = '0;
    lb_valid  = 1'b0;
    tick();
  endtask

  task automatic rand_beats(input int max_gap);
    for (int i = 0; i < 4; i++) begin
      beat_v[i] = {$urandom, $urandom};
      gap_v[i]  = $urandom_range(max_gap, 0);
    end
  endtask

  // One line request; beats and gaps come from beat_v/gap_v.
  task automatic do_line(input logic [31:0] a, input bit move_addr, input string tag);
    logic [255:0] exp_line;
    bit           hit;
    hit = 1'b0;
`ifdef ICACHE_LINE_ADAPTOR_LBUF_EN
    hit = lb_valid && (lb_tag == a[31:5]);
`endif
    line_read = 1'b1;
    line_addr = a;
    tick();
    if (hit) begin
      check({tag, ":hit_resp"}, line_resp, 1'b1);
      check({tag, ":hit_no_burst"}, burst_read, 1'b0);
      check({tag, ":hit_line"}, line_rdata, last_line);
      line_read = 1'b0;
      tick();
      check({tag, ":hit_resp_end"}, line_resp, 1'b0);
      return;
    end
    exp_line = {beat_v[3], beat_v[2], beat_v[1], beat_v[0]};
    exp_q.push_back(exp_line);
    check({tag, ":accept_read"}, burst_read, 1'b1);
    check({tag, ":accept_addr"}, burst_addr, a & 32'hFFFF_FFE0);
    if (move_addr) line_addr = 32'hFFFF_FFE0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < gap_v[i]; k++) begin
        tick();
        check({tag, ":gap_read"}, burst_read, 1'b1);
        check({tag, ":gap_resp"}, line_resp, 1'b0);
      end
      burst_resp  = 1'b1;
      burst_rdata = beat_v[i];
      tick();
      burst_resp  = 1'b0;
      burst_rdata = {$urandom, $urandom};
      if (i < 3) begin
        check({tag, ":beat_read"}, burst_read, 1'b1);
        check({tag, ":beat_addr"}, burst_addr, a & 32'hFFFF_FFE0);
        check({tag, ":beat_resp"}, line_resp, 1'b0);
      end
    end
    check({tag, ":done_resp"}, line_resp, 1'b1);
    check({tag, ":done_read"}, burst_read, 1'b0);
    check({tag, ":done_addr"}, burst_addr, 32'h0);
    check({tag, ":done_line"}, line_rdata, exp_q.pop_front());
    last_line = exp_line;
    lb_valid  = 1'b1;
    lb_tag    = a[31:5];
    line_read = 1'b0;
    tick();
    check({tag, ":idle_resp"}, line_resp, 1'b0);
    check({tag, ":idle_line"}, line_rdata, last_line);
  endtask

  initial begin
    rst_n       = 1'b0;
    line_read   = 1'b0;
    line_addr   = 32'h0;
    burst_rdata = 64'h0;
    burst_resp  = 1'b0;
    last_line   = '0;
    lb_valid    = 1'b0;
    lb_tag      = '0;
    #1;
    check("rst_line", line_rdata, 256'h0);
    check("rst_resp", line_resp, 1'b0);
    check("rst_read", burst_read, 1'b0);
    check("rst_addr", burst_addr, 32'h0);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    tick();

    // consecutive beats
    beat_v = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
               64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    gap_v  = '{0, 0, 0, 0};
    do_line(32'h0000_1234, 1'b0, "basic");

    // two idle cycles between the first and second beat
    do_reset();
    gap_v = '{0, 2, 0, 0};
    do_line(32'h0000_1234, 1'b0, "gapped");

    // line_addr moves during the burst
    do_reset();
    gap_v = '{0, 0, 1, 0};
    do_line(32'h0000_1234, 1'b1, "addr_move");

    // stray beats while idle
    for (int i = 0; i < 3; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
      tick();
      burst_resp = 1'b0;
      check("idle_beat_line", line_rdata, last_line);
      check("idle_beat_resp", line_resp, 1'b0);
    end
    rand_beats(1);
    do_line(32'h0000_5678, 1'b0, "after_idle_beats");

    // reset after two beats
    line_read = 1'b1;
    line_addr = 32'h0000_9ABC;
    tick();
    for (int i = 0; i < 2; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
      tick();
    end
    burst_resp = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("abort_read", burst_read, 1'b0);
    check("abort_resp", line_resp, 1'b0);
    check("abort_addr", burst_addr, 32'h0);
    check("abort_line", line_rdata, 256'h0);
    line_read = 1'b0;
    last_line = '0;
    lb_valid  = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      burst_resp  = 1'b1;
      burst_rdata = {$urandom, $urandom};
      tick();
      burst_resp = 1'b0;
      check("abort_tail_resp", line_resp, 1'b0);
      check("abort_tail_line", line_rdata, 256'h0);
    end
    rand_beats(0);
    do_line(32'h0000_9ABC, 1'b0, "restart");

`ifdef ICACHE_LINE_ADAPTOR_LBUF_EN
    do_reset();
    rand_beats(1);
    do_line(32'h0000_1220, 1'b0, "lbuf_fill");
    do_line(32'h0000_1220, 1'b0, "lbuf_hit");
    rand_beats(1);
    do_line(32'h0000_1240, 1'b0, "lbuf_miss");
`endif

    // randomized lines, addresses drawn from a small window so repeats occur
    for (int n = 0; n < 8; n++) begin
      rand_beats(3);
      do_line({$urandom_range(3, 0), 5'($urandom)}, 1'($urandom_range(1, 0)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_line_adaptor.md
ICACHE_LINE_ADAPTOR -- requirements
Module: icache_line_adaptor

Interface
REQ-001 SHALL have parameter S_OFFSET, default 5, log2 of line bytes.
REQ-002 SHALL have parameter S_LINE, default 256, line width in bits.
REQ-003 SHALL have parameter BURST_W, default 64, memory beat width in bits; BURST_LEN = S_LINE/BURST_W (4).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port line_read  input  1  icache miss request, held until line_resp.
REQ-007 SHALL have port line_addr  input  32  icache miss address (pipe-stage address).
REQ-008 SHALL have port line_rdata  output  S_LINE  assembled line to icache pmem_rdata.
REQ-009 SHALL have port line_resp  output  1  one-cycle line-ready strobe.
REQ-010 SHALL have port burst_addr  output  32  line-aligned memory address.
REQ-011 SHALL have port burst_read  output  1  memory burst request.
REQ-012 SHALL have port burst_rdata  input  BURST_W  memory beat data.
REQ-013 SHALL have port burst_resp  input  1  beat valid.

Function
REQ-014 SHALL implement states IDLE, BURST, DONE; all outputs registered or decoded from state only.
REQ-015 IDLE: line_read=1 at edge -> latch {line_addr[31:S_OFFSET], 5'b0} into addr register, clear beat counter, go BURST.
REQ-016 BURST: burst_read=1, burst_addr=latched address; line_addr changes are ignored.
REQ-017 BURST: each edge with burst_resp=1 writes burst_rdata into line bits [cnt*BURST_W +: BURST_W], cnt increments (2-bit, beat 0 = lowest bits); beats need not be consecutive.
REQ-018 BURST: edge capturing beat BURST_LEN-1 -> DONE; burst_read deasserts in DONE.
REQ-019 DONE: line_resp=1 for exactly one cycle, then IDLE unconditionally; line_read during DONE is not a new request.
REQ-020 Minimum latency: line_read sampled at edge 0, beats at edges 1-4, line_resp high during cycle after edge 4.
REQ-021 line_rdata SHALL hold last completed line until next BURST begins overwriting it; partially filled line is never flagged by line_resp.
REQ-022 burst_resp in IDLE or DONE SHALL be ignored (no data write, no counter change).
REQ-023 burst_addr SHALL be 0 and burst_read 0 outside BURST.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, cnt=0, addr=0, line_rdata=0, line_resp=0, burst_read=0, burst_addr=0.
REQ-025 Reset mid-burst SHALL abort without line_resp; remaining beats after release ignored per REQ-022 unless a new request starts.

Configuration
REQ-026 With ICACHE_LINE_ADAPTOR_LBUF_EN defined: keep valid bit + tag (addr[31:S_OFFSET]) of last completed line; IDLE request with valid matching tag goes directly to DONE (no burst, line_resp one cycle after acceptance, line_rdata unchanged).
REQ-027 LBUF valid SHALL set on BURST->DONE, clear on reset and on aborted burst; without the macro every request bursts and no tag storage exists.

Structure
REQ-028 State enum (adaptor_state_t) and BURST_LEN/BURST_W constants SHALL live in rv32i_types.
REQ-029 One sub-module, line_assembler (beat counter + S_LINE shift-in register), is natural; FSM stays in icache_line_adaptor.

Verification
REQ-030 Request 0x0000_1234, beats 0x11..11,0x22..22,0x33..33,0x44..44 on consecutive cycles -> burst_addr 0x0000_1220, line_rdata {44..,33..,22..,11..}, line_resp one cycle after 4th beat.
REQ-031 Same request with 2 idle cycles between beats 1 and 2 -> identical line, line_resp delayed 2 cycles, burst_read held throughout.
REQ-032 rst_n low after 2 beats -> burst_read 0 same cycle, no line_resp, next request restarts at beat 0.
REQ-033 burst_resp pulses while IDLE -> line_rdata and counter unchanged.
REQ-034 LBUF_EN: request 0x0000_1220 twice -> one burst only, second line_resp one cycle after acceptance, same data; request 0x0000_1240 -> new burst.
REQ-035 line_addr changed to 0xFFFF_FFE0 mid-burst -> burst_addr stays 0x0000_1220.
